// File: rtl/ppu_tile_converter_if.sv
// Control, framebuffer-read and staging-write signals of the PPU tile converter.
// The converter side uses the master modport; the flow controller / memories use slave.
interface ppu_tile_converter_if #(
  parameter int FB_ADDR_BITS  = 16,
  parameter int OUT_ADDR_BITS = 14
);
  logic                     start_tick;
  logic                     done_tick;
  logic                     busy;
  logic [FB_ADDR_BITS-1:0]  fb_read_addr;
  logic [7:0]               fb_read_data;
  logic                     out_write_valid;
  logic                     out_write_ready;
  logic [OUT_ADDR_BITS-1:0] out_write_addr;
  logic [15:0]              out_write_data;
  logic [15:0]              tiles_done;

  modport master (
    input  start_tick, fb_read_data, out_write_ready,
    output done_tick, busy, fb_read_addr, out_write_valid,
           out_write_addr, out_write_data, tiles_done
  );

  modport slave (
    output start_tick, fb_read_data, out_write_ready,
    input  done_tick, busy, fb_read_addr, out_write_valid,
           out_write_addr, out_write_data, tiles_done
  );
endinterface

// File: rtl/ppu_tile_converter.sv
// Converts the finished framebuffer into SNES 4bpp planar tiles, one 8-pixel tile row
// at a time: 8 reads, one drain cycle for the RAM latency, then two 16-bit plane words.
module ppu_tile_converter #(
  parameter int TILES_X       = 25,
  parameter int TILES_Y       = 20,
  parameter int FB_ADDR_BITS  = 16,
  parameter int OUT_ADDR_BITS = 14
) (
  input logic                  clock,
  input logic                  reset,
  ppu_tile_converter_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WR_LO, WR_HI, FINISH} state_t;

  localparam int ROW_PIXELS = 8 * TILES_X;

  state_t                   state_q;
  logic [15:0]              tx_q, ty_q, tilesDone_q;
  logic [2:0]               row_q, col_q;
  logic [3:0][7:0]          plane_q;
  logic                     doneTick_q, busy_q, valid_q;
  logic [FB_ADDR_BITS-1:0]  fbAddr_q;
  logic [OUT_ADDR_BITS-1:0] outAddr_q;
  logic [15:0]              outData_q;

  logic [2:0]      capCol, row_d;
  logic [3:0][7:0] plane_d;
  logic [15:0]     tx_d, ty_d;
  logic            lastRow, lastTileCol, lastPass;
  logic [31:0]     tileBase, rowBase_d;

  // The RAM answers one cycle late, so the byte arriving now belongs to the previous column.
  always_comb begin
    capCol  = (state_q == DRAIN) ? 3'd7 : col_q - 3'd1;
    plane_d = plane_q;
    for (int k = 0; k < 4; k++) plane_d[k][3'd7 - capCol] = bus.fb_read_data[k];
  end

  always_comb begin
    lastRow     = (row_q == 3'd7);
    lastTileCol = (tx_q == 16'(TILES_X - 1));
    lastPass    = lastRow && lastTileCol && (ty_q == 16'(TILES_Y - 1));
    row_d       = row_q + 3'd1;
    tx_d        = tx_q;
    ty_d        = ty_q;
    if (lastRow) begin
      tx_d = lastTileCol ? 16'd0 : tx_q + 16'd1;
      ty_d = lastTileCol ? ty_q + 16'd1 : ty_q;
    end
    tileBase  = ({16'd0, ty_q} * 32'(TILES_X) + {16'd0, tx_q}) << 4;
    rowBase_d = ({16'd0, ty_d} * 32'd8 + {29'd0, row_d}) * 32'(ROW_PIXELS)
              + {16'd0, tx_d} * 32'd8;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      ty_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      tilesDone_q <= '0;
      plane_q     <= '0;
      doneTick_q  <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      fbAddr_q    <= '0;
      outAddr_q   <= '0;
      outData_q   <= '0;
    end else begin
      doneTick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_tick) begin
            tx_q        <= '0;
            ty_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            tilesDone_q <= '0;
            fbAddr_q    <= '0;
            busy_q      <= 1'b1;
            state_q     <= READ;
          end
        end
        READ: begin
          if (col_q != 3'd0) plane_q <= plane_d;
          if (col_q == 3'd7) begin
            state_q <= DRAIN;
          end else begin
            col_q    <= col_q + 3'd1;
            fbAddr_q <= fbAddr_q + FB_ADDR_BITS'(1);
          end
        end
        DRAIN: begin
          plane_q   <= plane_d;
          valid_q   <= 1'b1;
          outAddr_q <= OUT_ADDR_BITS'(tileBase + {29'd0, row_q});
          outData_q <= {plane_d[1], plane_d[0]};
          state_q   <= WR_LO;
        end
        WR_LO: begin
          if (bus.out_write_ready) begin
            outAddr_q <= OUT_ADDR_BITS'(tileBase + 32'd8 + {29'd0, row_q});
            outData_q <= {plane_q[3], plane_q[2]};
            state_q   <= WR_HI;
          end
        end
        WR_HI: begin
          if (bus.out_write_ready) begin
            valid_q <= 1'b0;
            row_q   <= row_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            col_q   <= '0;
            if (lastRow) tilesDone_q <= tilesDone_q + 16'd1;
            if (lastPass) begin
              busy_q     <= 1'b0;
              doneTick_q <= 1'b1;
              state_q    <= FINISH;
            end else begin
              fbAddr_q <= FB_ADDR_BITS'(rowBase_d);
              state_q  <= READ;
            end
          end
        end
        FINISH: state_q <= IDLE;
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.done_tick       = doneTick_q;
  assign bus.busy            = busy_q;
  assign bus.fb_read_addr    = fbAddr_q;
  assign bus.out_write_valid = valid_q;
  assign bus.out_write_addr  = outAddr_q;
  assign bus.out_write_data  = outData_q;
  assign bus.tiles_done      = tilesDone_q;

endmodule

// File: tb/tb_ppu_tile_converter.sv
// Scoreboard bench for ppu_tile_converter using a 1x1, a default 25x20 and a 3x2 instance
// sharing one clock and reset.
module tb_ppu_tile_converter;

  typedef struct packed {
    logic [13:0] addr;
    logic [15:0] data;
  } word_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ppu_tile_converter_if busA ();
  ppu_tile_converter_if busB ();
  ppu_tile_converter_if busC ();

  ppu_tile_converter #(.TILES_X(1), .TILES_Y(1)) dutA (.clock(clock), .reset(reset), .bus(busA));
  ppu_tile_converter dutB (.clock(clock), .reset(reset), .bus(busB));
  ppu_tile_converter #(.TILES_X(3), .TILES_Y(2)) dutC (.clock(clock), .reset(reset), .bus(busC));

  word_t       qA[$], qB[$], qC[$];
  int          modeA = 0, modeB = 2, modeC = 2;
  bit          stallA = 1'b0;
  bit          stalledA = 1'b0;
  int          stallCntA = 0;
  word_t       heldA;
  int          startA = 0, startB = 0, startC = 0;
  int          expCycA = 0, expCycB = 0, expCycC = 0;
  int          doneA = 0, doneB = 0, doneC = 0;
  int          writesB = 0;
  logic [15:0] memA [16];

  function automatic logic [7:0] pixelOf(input int mode, input int x, input int y);
    if (mode == 0) return (y == 0) ? 8'(x) : 8'h00;
    if (mode == 1) return 8'hF5;
    return 8'((x ^ y) & 15);
  endfunction

  function automatic logic [15:0] expWord(input int mode, input int tx, input int ty,
                                          input int row, input int hi);
    logic [3:0][7:0] p;
    logic [7:0]      pix;
    p = '0;
    for (int c = 0; c < 8; c++) begin
      pix = pixelOf(mode, 8 * tx + c, 8 * ty + row);
      for (int k = 0; k < 4; k++) p[k][7 - c] = pix[k];
    end
    return (hi != 0) ? {p[3], p[2]} : {p[1], p[0]};
  endfunction

  function automatic int doneCount(input int which);
    if (which == 0) return doneA;
    if (which == 1) return doneB;
    return doneC;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Queue the full expected write sequence of a pass, then pulse start on that instance.
  task automatic applyStimulus(input int which, input int mode, input int tilesX,
                               input int tilesY, input bit stall, input int expCycle);
    word_t w;
    for (int ty = 0; ty < tilesY; ty++)
      for (int tx = 0; tx < tilesX; tx++)
        for (int row = 0; row < 8; row++)
          for (int hi = 0; hi < 2; hi++) begin
            w.addr = 14'((ty * tilesX + tx) * 16 + hi * 8 + row);
            w.data = expWord(mode, tx, ty, row, hi);
            if (which == 0) qA.push_back(w);
            else if (which == 1) qB.push_back(w);
            else qC.push_back(w);
          end
    if (which == 0) begin modeA = mode; stallA = stall; expCycA = expCycle; end
    else if (which == 1) begin modeB = mode; expCycB = expCycle; end
    else begin modeC = mode; expCycC = expCycle; end
    @(negedge clock);
    if (which == 0) begin busA.start_tick = 1'b1; startA = cyc; end
    else if (which == 1) begin busB.start_tick = 1'b1; startB = cyc; end
    else begin busC.start_tick = 1'b1; startC = cyc; end
    @(negedge clock);
    busA.start_tick = 1'b0;
    busB.start_tick = 1'b0;
    busC.start_tick = 1'b0;
  endtask

  task automatic waitDone(input int which, input int target, input int limit);
    int n = 0;
    while (doneCount(which) < target && n < limit) begin
      @(negedge clock);
      n++;
    end
    checkOutput("done within bound", 32'(doneCount(which) >= target), 32'd1);
  endtask

  task automatic clearMemA();
    for (int i = 0; i < 16; i++) memA[i] = 16'hDEAD;
  endtask

  // Framebuffer RAMs with one cycle of read latency.
  always @(posedge clock) begin
    busA.fb_read_data <= pixelOf(modeA, int'(busA.fb_read_addr) % 8, int'(busA.fb_read_addr) / 8);
    busB.fb_read_data <= pixelOf(modeB, int'(busB.fb_read_addr) % 200, int'(busB.fb_read_addr) / 200);
    busC.fb_read_data <= pixelOf(modeC, int'(busC.fb_read_addr) % 24, int'(busC.fb_read_addr) / 24);
  end

  // Instance A: optional ready stalls on WR_LO, stability check, scoreboard pop.
  always @(negedge clock) begin
    word_t w;
    if (!reset) begin
      if (stalledA) begin
        checkOutput("A stall valid", 32'(busA.out_write_valid), 32'd1);
        checkOutput("A stall addr", 32'(busA.out_write_addr), 32'(heldA.addr));
        checkOutput("A stall data", 32'(busA.out_write_data), 32'(heldA.data));
      end
      stalledA = 1'b0;
      if (stallA && busA.out_write_valid && !busA.out_write_addr[3] && stallCntA < 3) begin
        busA.out_write_ready = 1'b0;
        stallCntA++;
        stalledA   = 1'b1;
        heldA.addr = busA.out_write_addr;
        heldA.data = busA.out_write_data;
      end else begin
        busA.out_write_ready = 1'b1;
        if (!busA.out_write_valid || busA.out_write_addr[3]) stallCntA = 0;
      end
      if (busA.out_write_valid && busA.out_write_ready) begin
        checkOutput("A write expected", 32'(qA.size() != 0), 32'd1);
        if (qA.size() != 0) begin
          w = qA.pop_front();
          checkOutput("A addr", 32'(busA.out_write_addr), 32'(w.addr));
          checkOutput("A data", 32'(busA.out_write_data), 32'(w.data));
          memA[busA.out_write_addr[3:0]] = busA.out_write_data;
        end
      end
      if (busA.done_tick) begin
        doneA++;
        checkOutput("A done cycle", 32'(cyc - startA), 32'(expCycA));
        checkOutput("A busy at done", 32'(busA.busy), 32'd0);
      end
    end else begin
      busA.out_write_ready = 1'b1;
      stalledA  = 1'b0;
      stallCntA = 0;
    end
  end

  always @(negedge clock) begin
    word_t w;
    if (!reset) begin
      if (busB.out_write_valid && busB.out_write_ready) begin
        writesB++;
        checkOutput("B write expected", 32'(qB.size() != 0), 32'd1);
        if (qB.size() != 0) begin
          w = qB.pop_front();
          checkOutput("B addr", 32'(busB.out_write_addr), 32'(w.addr));
          checkOutput("B data", 32'(busB.out_write_data), 32'(w.data));
        end
      end
      if (busB.done_tick) begin
        doneB++;
        checkOutput("B done cycle", 32'(cyc - startB), 32'(expCycB));
      end
    end
  end

  always @(negedge clock) begin
    word_t w;
    if (!reset) begin
      if (busC.out_write_valid && busC.out_write_ready) begin
        checkOutput("C write expected", 32'(qC.size() != 0), 32'd1);
        if (qC.size() != 0) begin
          w = qC.pop_front();
          checkOutput("C addr", 32'(busC.out_write_addr), 32'(w.addr));
          checkOutput("C data", 32'(busC.out_write_data), 32'(w.data));
        end
      end
      if (busC.done_tick) begin
        doneC++;
        checkOutput("C done cycle", 32'(cyc - startC), 32'(expCycC));
      end
    end
  end

  initial begin
    int n;
    busA.start_tick      = 1'b0;
    busB.start_tick      = 1'b0;
    busC.start_tick      = 1'b0;
    busB.out_write_ready = 1'b1;
    busC.out_write_ready = 1'b1;
    clearMemA();
    repeat (3) @(negedge clock);
    checkOutput("reset busy", 32'(busA.busy), 32'd0);
    checkOutput("reset done", 32'(busA.done_tick), 32'd0);
    checkOutput("reset valid", 32'(busA.out_write_valid), 32'd0);
    checkOutput("reset fb addr", 32'(busA.fb_read_addr), 32'd0);
    checkOutput("reset tiles", 32'(busA.tiles_done), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] single tile, row 0 ramp");
    clearMemA();
    applyStimulus(0, 0, 1, 1, 1'b0, 89);
    waitDone(0, 1, 200);
    checkOutput("T1 word0", 32'(memA[0]), 32'h3355);
    checkOutput("T1 word8", 32'(memA[8]), 32'h000F);
    checkOutput("T1 word5", 32'(memA[5]), 32'h0000);
    checkOutput("T1 queue empty", 32'(qA.size()), 32'd0);
    checkOutput("T1 tiles", 32'(busA.tiles_done), 32'd1);

    $display("[TB] single tile with ready stalls");
    clearMemA();
    applyStimulus(0, 0, 1, 1, 1'b1, 113);
    waitDone(0, 2, 300);
    stallA = 1'b0;
    checkOutput("T3 word0", 32'(memA[0]), 32'h3355);
    checkOutput("T3 word8", 32'(memA[8]), 32'h000F);
    checkOutput("T3 queue empty", 32'(qA.size()), 32'd0);

    $display("[TB] upper nibble ignored");
    clearMemA();
    applyStimulus(0, 1, 1, 1, 1'b0, 89);
    waitDone(0, 3, 200);
    checkOutput("T6 word0", 32'(memA[0]), 32'h00FF);
    checkOutput("T6 word15", 32'(memA[15]), 32'h00FF);

    $display("[TB] start ignored while busy and during done");
    applyStimulus(0, 0, 1, 1, 1'b0, 89);
    repeat (20) @(negedge clock);
    busA.start_tick = 1'b1;
    @(negedge clock);
    busA.start_tick = 1'b0;
    repeat (67) @(negedge clock);
    checkOutput("T4 done aligned", 32'(busA.done_tick), 32'd1);
    busA.start_tick = 1'b1;
    @(negedge clock);
    busA.start_tick = 1'b0;
    repeat (100) @(negedge clock);
    checkOutput("T4 single done", 32'(doneA), 32'd4);
    checkOutput("T4 queue empty", 32'(qA.size()), 32'd0);
    checkOutput("T4 idle", 32'(busA.busy), 32'd0);

    $display("[TB] full 25x20 pass");
    applyStimulus(1, 2, 25, 20, 1'b0, 44001);
    waitDone(1, 1, 45000);
    checkOutput("T2 tiles", 32'(busB.tiles_done), 32'd500);
    checkOutput("T2 writes", 32'(writesB), 32'd8000);
    checkOutput("T2 queue empty", 32'(qB.size()), 32'd0);

    $display("[TB] reset during WR_HI of tile 3");
    applyStimulus(2, 2, 3, 2, 1'b0, 529);
    n = 0;
    while (!(busC.out_write_valid && busC.out_write_addr == 14'd56) && n < 400) begin
      @(negedge clock);
      n++;
    end
    checkOutput("T5 reached tile 3", 32'(n < 400), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("T5 done", 32'(busC.done_tick), 32'd0);
    checkOutput("T5 busy", 32'(busC.busy), 32'd0);
    checkOutput("T5 valid", 32'(busC.out_write_valid), 32'd0);
    checkOutput("T5 fb addr", 32'(busC.fb_read_addr), 32'd0);
    checkOutput("T5 out addr", 32'(busC.out_write_addr), 32'd0);
    checkOutput("T5 out data", 32'(busC.out_write_data), 32'd0);
    checkOutput("T5 tiles", 32'(busC.tiles_done), 32'd0);
    qC.delete();
    @(negedge clock);
    reset = 1'b0;
    checkOutput("T5 no done", 32'(doneC), 32'd0);
    applyStimulus(2, 2, 3, 2, 1'b0, 529);
    waitDone(2, 1, 700);
    checkOutput("T5 restart tiles", 32'(busC.tiles_done), 32'd6);
    checkOutput("T5 queue empty", 32'(qC.size()), 32'd0);
    repeat (5) @(negedge clock);
    checkOutput("T5 one done", 32'(doneC), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
